// File: rtl/fm_dump_byte_packer.sv
// fm_dump_byte_packer: buffers IQ/audio samples in a small FIFO and serialises them MSB-first into dump bytes
module fm_dump_byte_packer #(
  parameter int FIFO_AW = 3
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               enable,
  input  logic               mode,
  input  logic               sample_valid,
  input  logic [15:0]        i_sample,
  input  logic [15:0]        q_sample,
  input  logic [15:0]        audio_sample,
  input  logic               byte_req,
  output logic [7:0]         dump_data,
  output logic               dump_valid,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow,
  output logic               underrun,
  output logic [15:0]        byte_count
);
  typedef enum logic [1:0] {IDLE, EMPTY, SEND} state_t;
  state_t state, state_n;
  logic enable_d, mode_l, rise, mode_eff, empty, full, last, emit, pop, push_req, push;
  logic [31:0] mem [2**FIFO_AW];
  logic [FIFO_AW-1:0] wp, rp;
  logic [31:0] sh;
  logic [1:0] idx;
  assign rise     = enable & ~enable_d;
  // samples arriving on the enable-rise cycle already follow the newly latched mode
  assign mode_eff = rise ? mode : mode_l;
  assign empty    = fifo_level == '0;
  assign full     = fifo_level[FIFO_AW];
  assign last     = idx == (mode_l ? 2'd1 : 2'd3);
  assign emit     = enable && state == SEND && byte_req;
  assign pop      = enable && !empty && (state == EMPTY || (emit && last));
  assign push_req = enable && sample_valid;
  assign push     = push_req && (!full || pop);
  always_comb begin
    state_n = state;
    if (!enable) state_n = IDLE;
    else if (rise) state_n = EMPTY;
    else if (state == EMPTY && !empty) state_n = SEND;
    else if (emit && last && empty) state_n = EMPTY;
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= mode_eff ? {16'h0, audio_sample} : {i_sample, q_sample};
  always_ff @(posedge clk) begin
    if (RST) begin
      state      <= IDLE;
      enable_d   <= 1'b0;
      mode_l     <= 1'b0;
      wp         <= '0;
      rp         <= '0;
      fifo_level <= '0;
      sh         <= '0;
      idx        <= '0;
      dump_data  <= '0;
      dump_valid <= 1'b0;
      overflow   <= 1'b0;
      underrun   <= 1'b0;
      byte_count <= '0;
    end else begin
      state      <= state_n;
      enable_d   <= enable;
      dump_valid <= emit;
      if (!enable) begin
        wp         <= '0;
        rp         <= '0;
        fifo_level <= '0;
        sh         <= '0;
        idx        <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop) rp <= rp + 1'b1;
        fifo_level <= fifo_level + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        // audio words are left-aligned so the next byte is always sh[31:24]
        if (pop) begin
          sh  <= mode_l ? {mem[rp][15:0], 16'h0} : mem[rp];
          idx <= '0;
        end else if (emit) begin
          sh  <= {sh[23:0], 8'h0};
          idx <= idx + 2'd1;
        end
        if (emit) dump_data <= sh[31:24];
        if (rise) begin
          mode_l     <= mode;
          overflow   <= 1'b0;
          underrun   <= 1'b0;
          byte_count <= '0;
        end else begin
          if (push_req && !push) overflow <= 1'b1;
          if (state == EMPTY && byte_req) underrun <= 1'b1;
          if (emit && byte_count != 16'hFFFF) byte_count <= byte_count + 16'd1;
        end
      end
    end
  end
endmodule
